// File: rtl/tlb_set_storage.sv
// +----------------------------------------------------------------------------+
// | tlb_set_storage: TLB set-associative entry/LRU storage, comb. set read.     |
// | Optional: TLB_LRU_LOAD_EN (LRU update loads lru_value). Revision: 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tlb_set_storage #(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SET_INDEX_BITS-1:0]      rd_set_index,
  output logic [NUM_WAYS-1:0]            rd_valid,
  output logic [NUM_WAYS*20-1:0]         rd_vpn,
  output logic [NUM_WAYS*20-1:0]         rd_ppn,
  output logic [NUM_WAYS*2-1:0]          rd_perms,
  output logic [NUM_WAYS*LRU_BITS-1:0]   rd_lru_count,
  input  logic                           wr_en,
  input  logic [SET_INDEX_BITS-1:0]      wr_set_index,
  input  logic [1:0]                     wr_way,
  input  logic                           wr_valid,
  input  logic [19:0]                    wr_vpn,
  input  logic [19:0]                    wr_ppn,
  input  logic [1:0]                     wr_perms,
  input  logic [LRU_BITS-1:0]            wr_lru_count,
  input  logic                           lru_update_en,
  input  logic [SET_INDEX_BITS-1:0]      lru_set_index,
  input  logic [1:0]                     lru_way,
  input  logic [LRU_BITS-1:0]            lru_value
);

  localparam logic [LRU_BITS-1:0] LRU_MAX = {LRU_BITS{1'b1}};

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [19:0]         vpn_q   [NUM_SETS][NUM_WAYS];
  logic [19:0]         vpn_d   [NUM_SETS][NUM_WAYS];
  logic [19:0]         ppn_q   [NUM_SETS][NUM_WAYS];
  logic [19:0]         ppn_d   [NUM_SETS][NUM_WAYS];
  logic [1:0]          perms_q [NUM_SETS][NUM_WAYS];
  logic [1:0]          perms_d [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] lru_q   [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] lru_d   [NUM_SETS][NUM_WAYS];

  function automatic logic [LRU_BITS-1:0] sat_inc(input logic [LRU_BITS-1:0] v);
    return (v == LRU_MAX) ? v : v + LRU_BITS'(1);
  endfunction

`ifndef TLB_LRU_LOAD_EN
  logic unused_lru_value;
  assign unused_lru_value = ^lru_value;
`endif

  // The write is applied after the LRU update so it wins on a same-entry collision.
  always_comb begin
    valid_d = valid_q;
    vpn_d   = vpn_q;
    ppn_d   = ppn_q;
    perms_d = perms_q;
    lru_d   = lru_q;
    if (lru_update_en) begin
`ifdef TLB_LRU_LOAD_EN
      lru_d[lru_set_index][lru_way] = lru_value;
`else
      lru_d[lru_set_index][lru_way] = sat_inc(lru_q[lru_set_index][lru_way]);
`endif
    end
    if (wr_en) begin
      valid_d[wr_set_index][wr_way] = wr_valid;
      vpn_d[wr_set_index][wr_way]   = wr_vpn;
      ppn_d[wr_set_index][wr_way]   = wr_ppn;
      perms_d[wr_set_index][wr_way] = wr_perms;
      lru_d[wr_set_index][wr_way]   = sat_inc(wr_lru_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          vpn_q[s][w]   <= '0;
          ppn_q[s][w]   <= '0;
          perms_q[s][w] <= '0;
          lru_q[s][w]   <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      vpn_q   <= vpn_d;
      ppn_q   <= ppn_d;
      perms_q <= perms_d;
      lru_q   <= lru_d;
    end
  end

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_rd_way
      assign rd_valid[w]                         = valid_q[rd_set_index][w];
      assign rd_vpn[w*20 +: 20]                  = vpn_q[rd_set_index][w];
      assign rd_ppn[w*20 +: 20]                  = ppn_q[rd_set_index][w];
      assign rd_perms[w*2 +: 2]                  = perms_q[rd_set_index][w];
      assign rd_lru_count[w*LRU_BITS +: LRU_BITS] = lru_q[rd_set_index][w];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tlb_set_storage.sv
// +----------------------------------------------------------------------------+
// | tb_tlb_set_storage: directed self-checking bench for tlb_set_storage.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tlb_set_storage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_set_index;
  logic [3:0]  rd_valid;
  logic [79:0] rd_vpn;
  logic [79:0] rd_ppn;
  logic [7:0]  rd_perms;
  logic [15:0] rd_lru_count;
  logic        wr_en;
  logic [3:0]  wr_set_index;
  logic [1:0]  wr_way;
  logic        wr_valid;
  logic [19:0] wr_vpn;
  logic [19:0] wr_ppn;
  logic [1:0]  wr_perms;
  logic [3:0]  wr_lru_count;
  logic        lru_update_en;
  logic [3:0]  lru_set_index;
  logic [1:0]  lru_way;
  logic [3:0]  lru_value;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_set_storage dut (
    .clk           (clk),
    .rst           (rst),
    .rd_set_index  (rd_set_index),
    .rd_valid      (rd_valid),
    .rd_vpn        (rd_vpn),
    .rd_ppn        (rd_ppn),
    .rd_perms      (rd_perms),
    .rd_lru_count  (rd_lru_count),
    .wr_en         (wr_en),
    .wr_set_index  (wr_set_index),
    .wr_way        (wr_way),
    .wr_valid      (wr_valid),
    .wr_vpn        (wr_vpn),
    .wr_ppn        (wr_ppn),
    .wr_perms      (wr_perms),
    .wr_lru_count  (wr_lru_count),
    .lru_update_en (lru_update_en),
    .lru_set_index (lru_set_index),
    .lru_way       (lru_way),
    .lru_value     (lru_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry packed as {valid, vpn, ppn, perms, lru} = 47 bits.
  task automatic check_entry(input string tag, input int set, input int way,
                             input logic v, input logic [19:0] vpn,
                             input logic [19:0] ppn, input logic [1:0] perms,
                             input logic [3:0] lru);
    logic [46:0] got;
    logic [46:0] exp;
    rd_set_index = 4'(set);
    #1;
    got = {rd_valid[way], rd_vpn[way*20 +: 20], rd_ppn[way*20 +: 20],
           rd_perms[way*2 +: 2], rd_lru_count[way*4 +: 4]};
    exp = {v, vpn, ppn, perms, lru};
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s set=%0d way=%0d observed=%h expected=%h", tag, set, way, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        check_entry(tag, s, w, 1'b0, 20'h0, 20'h0, 2'b00, 4'h0);
  endtask

  task automatic write(input int set, input int way, input logic v,
                       input logic [19:0] vpn, input logic [19:0] ppn,
                       input logic [1:0] perms, input logic [3:0] lru);
    wr_en        = 1'b1;
    wr_set_index = 4'(set);
    wr_way       = 2'(way);
    wr_valid     = v;
    wr_vpn       = vpn;
    wr_ppn       = ppn;
    wr_perms     = perms;
    wr_lru_count = lru;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic update(input int set, input int way);
    lru_update_en = 1'b1;
    lru_set_index = 4'(set);
    lru_way       = 2'(way);
    lru_value     = 4'h9;
    tick();
    lru_update_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_set_index = '0;
    wr_en = 1'b0; wr_set_index = '0; wr_way = '0; wr_valid = 1'b0;
    wr_vpn = '0; wr_ppn = '0; wr_perms = '0; wr_lru_count = '0;
    lru_update_en = 1'b0; lru_set_index = '0; lru_way = '0; lru_value = '0;

    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    write(5, 2, 1'b1, 20'hABCDE, 20'h12345, 2'b11, 4'h0);
    check_entry("single_w2", 5, 2, 1'b1, 20'hABCDE, 20'h12345, 2'b11, 4'h1);
    check_entry("single_w0", 5, 0, 1'b0, 20'h0, 20'h0, 2'b00, 4'h0);
    check_entry("single_w1", 5, 1, 1'b0, 20'h0, 20'h0, 2'b00, 4'h0);
    check_entry("single_w3", 5, 3, 1'b0, 20'h0, 20'h0, 2'b00, 4'h0);

    write(3, 0, 1'b1, 20'h11111, 20'h22222, 2'b01, 4'h0);
    write(3, 1, 1'b1, 20'h33333, 20'h44444, 2'b10, 4'h0);
    write(3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h0);
    write(3, 3, 1'b1, 20'h77777, 20'h88888, 2'b00, 4'h0);
    check_entry("full_w0", 3, 0, 1'b1, 20'h11111, 20'h22222, 2'b01, 4'h1);
    check_entry("full_w1", 3, 1, 1'b1, 20'h33333, 20'h44444, 2'b10, 4'h1);
    check_entry("full_w2", 3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h1);
    check_entry("full_w3", 3, 3, 1'b1, 20'h77777, 20'h88888, 2'b00, 4'h1);
    write(3, 1, 1'b1, 20'hAAAAA, 20'hBBBBB, 2'b11, 4'h0);
    check_entry("ovr_w0", 3, 0, 1'b1, 20'h11111, 20'h22222, 2'b01, 4'h1);
    check_entry("ovr_w1", 3, 1, 1'b1, 20'hAAAAA, 20'hBBBBB, 2'b11, 4'h1);
    check_entry("ovr_w2", 3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h1);
    check_entry("ovr_w3", 3, 3, 1'b1, 20'h77777, 20'h88888, 2'b00, 4'h1);

    write(7, 0, 1'b1, 20'h07070, 20'h70707, 2'b10, 4'h0);
    check_entry("lru_fill", 7, 0, 1'b1, 20'h07070, 20'h70707, 2'b10, 4'h1);
    update(7, 0);
    check_entry("lru_upd1", 7, 0, 1'b1, 20'h07070, 20'h70707, 2'b10, 4'h2);
    for (int i = 0; i < 13; i++) update(7, 0);
    check_entry("lru_at15", 7, 0, 1'b1, 20'h07070, 20'h70707, 2'b10, 4'hF);
    for (int i = 0; i < 2; i++) update(7, 0);
    check_entry("lru_sat", 7, 0, 1'b1, 20'h07070, 20'h70707, 2'b10, 4'hF);
    write(7, 1, 1'b1, 20'h00001, 20'h00002, 2'b01, 4'hF);
    check_entry("lru_wr_sat", 7, 1, 1'b1, 20'h00001, 20'h00002, 2'b01, 4'hF);
    write(7, 2, 1'b1, 20'h00003, 20'h00004, 2'b00, 4'h7);
    check_entry("lru_wr_base7", 7, 2, 1'b1, 20'h00003, 20'h00004, 2'b00, 4'h8);
    update(8, 3);
    check_entry("upd_invalid", 8, 3, 1'b0, 20'h0, 20'h0, 2'b00, 4'h1);

    for (int i = 0; i < 16; i++)
      write(i, 0, 1'b1, 20'h10000 + 20'(i), 20'h20000 + 20'(i), 2'b11, 4'h0);
    for (int i = 0; i < 16; i++)
      check_entry("all_sets", i, 0, 1'b1, 20'h10000 + 20'(i), 20'h20000 + 20'(i), 2'b11, 4'h1);
    check_entry("all_sets_keep", 3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h1);

    // Write and update to different entries in the same cycle.
    lru_update_en = 1'b1; lru_set_index = 4'd3; lru_way = 2'd2; lru_value = 4'h9;
    write(2, 1, 1'b1, 20'hCAFE0, 20'hBEEF0, 2'b10, 4'h3);
    lru_update_en = 1'b0;
    check_entry("dual_wr", 2, 1, 1'b1, 20'hCAFE0, 20'hBEEF0, 2'b10, 4'h4);
    check_entry("dual_upd", 3, 2, 1'b1, 20'h55555, 20'h66666, 2'b11, 4'h2);

    // Same-entry collision: write wins.
    update(9, 2); update(9, 2);
    lru_update_en = 1'b1; lru_set_index = 4'd9; lru_way = 2'd2; lru_value = 4'h9;
    write(9, 2, 1'b1, 20'h99999, 20'h88888, 2'b01, 4'h5);
    lru_update_en = 1'b0;
    check_entry("collision", 9, 2, 1'b1, 20'h99999, 20'h88888, 2'b01, 4'h6);

    write(5, 2, 1'b0, 20'h00001, 20'h00002, 2'b01, 4'h0);
    check_entry("invalidate", 5, 2, 1'b0, 20'h00001, 20'h00002, 2'b01, 4'h1);

    // Single reset cycle with a write and an update pending; both must be dropped.
    rst = 1'b1;
    lru_update_en = 1'b1; lru_set_index = 4'd1; lru_way = 2'd0; lru_value = 4'h9;
    write(0, 0, 1'b1, 20'hFFFFF, 20'hFFFFF, 2'b11, 4'h2);
    lru_update_en = 1'b0;
    rst = 1'b0;
    check_all_zero("reset2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
